// File: rtl/step_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : step_counter_ctrl
// Description : Command sequencer for the 4-bit step counter. Steers the
//               counter's count to a requested target by issuing +3/+1 step
//               commands, chosen from the forward modular distance, or by a
//               single direct load. The counter's live count is the feedback.
// Ports       : clk, reset (async, active-low)
//               start, mode, abort, target, count_fb  - request side / feedback
//               load, count_en, c, data_in            - counter command side
//               busy, done, err                       - request status
// Revision    : 1.0 - initial release
// ============================================================================
module step_counter_ctrl #(
    parameter int WIDTH     = 4,
    parameter int MAX_STEPS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] count_fb,
    output logic             load,
    output logic             count_en,
    output logic [1:0]       c,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0]       C_PLUS3    = 2'b00;
    localparam logic [1:0]       C_PLUS1    = 2'b01;
    localparam logic [1:0]       C_HOLD     = 2'b11;
    localparam logic [WIDTH-1:0] THREE      = WIDTH'(3);
    localparam logic [SW-1:0]    STEP_LIMIT = SW'(MAX_STEPS);

    logic [2:0]       state;
    logic [WIDTH-1:0] tgt;
    logic [SW-1:0]    steps;
    logic [WIDTH-1:0] diff;

    // Forward distance only; modular subtraction makes wrap-around free.
    assign diff = tgt - count_fb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            tgt      <= '0;
            steps    <= '0;
            load     <= 1'b0;
            count_en <= 1'b0;
            c        <= C_HOLD;
            data_in  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != S_IDLE)) begin
                // Abort wins over every other transition; err is left as is.
                state    <= S_IDLE;
                load     <= 1'b0;
                count_en <= 1'b0;
                c        <= C_HOLD;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            tgt   <= target;
                            steps <= '0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            if (mode) begin
                                // Outputs are registered, so the load command
                                // is raised on entry to LOAD.
                                state   <= S_LOAD;
                                load    <= 1'b1;
                                data_in <= target;
                            end else begin
                                state <= S_EVAL;
                            end
                        end
                    end
                    S_LOAD: begin
                        load  <= 1'b0;
                        state <= S_EVAL;
                    end
                    S_EVAL: begin
                        if (diff == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (steps == STEP_LIMIT) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            count_en <= 1'b1;
                            c        <= (diff >= THREE) ? C_PLUS3 : C_PLUS1;
                            state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        // Counter samples the command at this edge; the next
                        // EVAL then sees the updated count, so no overshoot.
                        count_en <= 1'b0;
                        c        <= C_HOLD;
                        steps    <= steps + SW'(1);
                        state    <= S_EVAL;
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        state    <= S_IDLE;
                        load     <= 1'b0;
                        count_en <= 1'b0;
                        c        <= C_HOLD;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_step_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_counter_ctrl
// Description : Self-checking bench for step_counter_ctrl. A behavioural step
//               counter closes the feedback loop; request vectors come from a
//               table and expected outcomes are queued until done appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] count_fb;
    logic       load;
    logic       count_en;
    logic [1:0] c;
    logic [3:0] data_in;
    logic       busy;
    logic       done;
    logic       err;

    // Behavioural model of the external step counter.
    logic       preset_en = 1'b0;
    logic [3:0] preset_val = 4'd0;
    logic       stuck = 1'b0;
    logic [3:0] cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset)                   cnt <= 4'd0;
        else if (preset_en)           cnt <= preset_val;
        else if (!stuck) begin
            if (load)                 cnt <= data_in;
            else if (count_en) begin
                if (c == 2'b00)       cnt <= cnt + 4'd3;
                else if (c == 2'b01)  cnt <= cnt + 4'd1;
            end
        end
    end
    assign count_fb = cnt;

    step_counter_ctrl #(.WIDTH(4), .MAX_STEPS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .target   (target),
        .count_fb (count_fb),
        .load     (load),
        .count_en (count_en),
        .c        (c),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // lat = edges from the start edge to the edge that raises done.
    typedef struct {
        logic       mode;
        logic [3:0] init;
        logic [3:0] tgt;
        logic       stuck;
        logic       poke;   // fire a spurious start while busy
        int         n3;
        int         n1;
        int         nload;
        int         lat;
        logic       err;
    } vec_t;

    vec_t vecs[9];
    vec_t sb[$];

    task automatic begin_request(input logic m, input logic [3:0] init,
                                 input logic [3:0] tg, input logic stk);
        @(negedge clk);
        preset_en  = 1'b1;
        preset_val = init;
        stuck      = stk;
        @(negedge clk);
        preset_en = 1'b0;
        start     = 1'b1;
        mode      = m;
        target    = tg;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'd0,  4'd7,  1'b0, 1'b0, 2, 1, 0,  7, 1'b0};
        vecs[1] = '{1'b0, 4'd14, 4'd1,  1'b0, 1'b0, 1, 0, 0,  3, 1'b0};
        vecs[2] = '{1'b1, 4'd2,  4'd9,  1'b0, 1'b0, 0, 0, 1,  2, 1'b0};
        vecs[3] = '{1'b0, 4'd5,  4'd5,  1'b0, 1'b0, 0, 0, 0,  1, 1'b0};
        vecs[4] = '{1'b0, 4'd0,  4'd15, 1'b0, 1'b0, 5, 0, 0, 11, 1'b0};
        vecs[5] = '{1'b0, 4'd3,  4'd1,  1'b0, 1'b0, 4, 2, 0, 13, 1'b0};
        vecs[6] = '{1'b0, 4'd0,  4'd8,  1'b1, 1'b0, 8, 0, 0, 17, 1'b1};
        vecs[7] = '{1'b0, 4'd9,  4'd11, 1'b0, 1'b1, 0, 2, 0,  5, 1'b0};
        vecs[8] = '{1'b1, 4'd4,  4'd4,  1'b0, 1'b0, 0, 0, 1,  2, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_load",     int'(load),     0);
        chk("rst_count_en", int'(count_en), 0);
        chk("rst_c",        int'(c),        3);
        chk("rst_data_in",  int'(data_in),  0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_done",     int'(done),     0);
        chk("rst_err",      int'(err),      0);
        reset = 1'b1;

        // Table-driven requests
        for (int i = 0; i < 9; i++) begin
            int   k, n3, n1, nl;
            logic got, busy_ok, ld_ok;
            vec_t e;
            begin_request(vecs[i].mode, vecs[i].init, vecs[i].tgt, vecs[i].stuck);
            sb.push_back(vecs[i]);
            k = 0; n3 = 0; n1 = 0; nl = 0;
            got = 1'b0; busy_ok = 1'b1; ld_ok = 1'b1;
            chk("err_cleared_on_start", int'(err), 0);
            while (!got && k < 60) begin
                if (count_en && c == 2'b00) n3++;
                if (count_en && c == 2'b01) n1++;
                if (load) begin
                    nl++;
                    if (data_in != vecs[i].tgt) ld_ok = 1'b0;
                end
                if (!busy) busy_ok = 1'b0;
                if (done) begin
                    got = 1'b1;
                end else begin
                    if (vecs[i].poke && k == 2) begin
                        start  = 1'b1;
                        mode   = 1'b1;
                        target = ~vecs[i].tgt;
                    end else begin
                        start = 1'b0;
                    end
                    @(negedge clk);
                    k++;
                end
            end
            start = 1'b0;
            if (got) begin
                e = sb.pop_front();
                chk($sformatf("v%0d_latency", i), k,           e.lat);
                chk($sformatf("v%0d_plus3", i),   n3,          e.n3);
                chk($sformatf("v%0d_plus1", i),   n1,          e.n1);
                chk($sformatf("v%0d_loads", i),   nl,          e.nload);
                chk($sformatf("v%0d_load_val", i), int'(ld_ok), 1);
                chk($sformatf("v%0d_busy", i),    int'(busy_ok), 1);
                chk($sformatf("v%0d_err", i),     int'(err),   int'(e.err));
                @(negedge clk);
                chk($sformatf("v%0d_done_pulse", i), int'(done), 0);
                chk($sformatf("v%0d_busy_exit", i),  int'(busy), 0);
                chk($sformatf("v%0d_err_sticky", i), int'(err),  int'(e.err));
            end else begin
                void'(sb.pop_front());
                chk($sformatf("v%0d_done_timeout", i), 0, 1);
            end
        end

        // Abort during the second ISSUE of the 0 -> 7 request
        begin_request(1'b0, 4'd0, 4'd7, 1'b0);
        repeat (3) @(negedge clk);
        chk("abort_pre_issue", int'(count_en), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_count_en", int'(count_en), 0);
        chk("abort_c",        int'(c),        3);
        chk("abort_busy",     int'(busy),     0);
        chk("abort_done",     int'(done),     0);
        begin
            int nd = 0;
            repeat (10) begin
                @(negedge clk);
                if (done || busy || count_en) nd++;
            end
            chk("abort_stays_idle", nd, 0);
        end
        chk("abort_idle_no_effect_cnt", int'(count_fb), 6);

        // Asynchronous reset in the middle of a request
        begin_request(1'b0, 4'd0, 4'd7, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_busy",     int'(busy),     0);
        chk("async_rst_count_en", int'(count_en), 0);
        chk("async_rst_c",        int'(c),        3);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
